// File: rtl/gol_pkg.sv
// Shared types for the Game-of-Life generation engine.
package gol_pkg;

    localparam int ROWS  = 16;
    localparam int COLS  = 16;
    localparam int ROW_W = $clog2(ROWS);

    typedef logic [COLS-1:0]            row_t;
    typedef logic [ROWS-1:0][COLS-1:0]  grid_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        COMPUTE,
        COMMIT
    } state_t;

endpackage

// File: rtl/gol_row_eval.sv
// Combinational next-generation evaluation of one row from its two vertical neighbours.
module gol_row_eval
    import gol_pkg::*;
(
    input  row_t above_i,
    input  row_t cur_i,
    input  row_t below_i,
    output row_t next_o
);

    // One dead cell of padding on each side gives dead column edges with no special cases.
    logic [COLS+1:0] above_p;
    logic [COLS+1:0] cur_p;
    logic [COLS+1:0] below_p;

    assign above_p = {1'b0, above_i, 1'b0};
    assign cur_p   = {1'b0, cur_i,   1'b0};
    assign below_p = {1'b0, below_i, 1'b0};

    always_comb begin
        // NOTE: every variable gets a default before any conditional use, so no latch is inferred.
        logic [3:0] n;
        n      = '0;
        next_o = '0;
        for (int c = 0; c < COLS; c++) begin
            n = 4'(above_p[c]) + 4'(above_p[c+1]) + 4'(above_p[c+2])
              + 4'(cur_p[c])                      + 4'(cur_p[c+2])
              + 4'(below_p[c]) + 4'(below_p[c+1]) + 4'(below_p[c+2]);
            next_o[c] = (n == 4'd3) | (cur_i[c] & (n == 4'd2));
        end
    end

endmodule

// File: rtl/gol_next_gen.sv
// Game-of-Life generation engine: paces generations, computes one row per cycle, strobes the grid load.
module gol_next_gen
    import gol_pkg::*;
#(
    parameter int unsigned GEN_PERIOD = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        step,
    input  logic        edit,
    input  grid_t       grid,
    output grid_t       grid_next,
    output logic        enable_update,
    output logic        busy,
    output logic [15:0] gen_count
);

    localparam int CNT_W = (GEN_PERIOD > 1) ? $clog2(GEN_PERIOD) : 1;
    localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(GEN_PERIOD - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   row_q,   row_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [15:0]        gen_q,   gen_d;
    grid_t              grid_next_q;

    row_t row_above, row_cur, row_below, row_new;

    always_comb begin
        row_above = '0;
        row_below = '0;
        row_cur   = grid[row_q];
        if (row_q != '0)       row_above = grid[row_q - 1'b1];
        if (row_q != ROW_LAST) row_below = grid[row_q + 1'b1];
    end

    gol_row_eval u_row_eval (
        .above_i (row_above),
        .cur_i   (row_cur),
        .below_i (row_below),
        .next_o  (row_new)
    );

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        gen_d   = gen_q;
        unique case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = WAIT;
                    cnt_d   = RELOAD;
                end else if (step && !edit) begin
                    state_d = COMPUTE;
                    row_d   = '0;
                end
            end
            WAIT: begin
                if (!run) begin
                    state_d = IDLE;
                end else if (edit) begin
                    cnt_d = RELOAD;
                end else if (cnt_q == '0) begin
                    state_d = COMPUTE;
                    row_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            COMPUTE: begin
                if (edit) begin
                    state_d = run ? WAIT : IDLE;
                    cnt_d   = RELOAD;
                end else if (row_q == ROW_LAST) begin
                    state_d = COMMIT;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            COMMIT: begin
                gen_d   = gen_q + 16'd1;
                state_d = run ? WAIT : IDLE;
                cnt_d   = RELOAD;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            row_q       <= '0;
            cnt_q       <= '0;
            gen_q       <= '0;
            // NOTE: the row buffer is reset too, since it is a visible output with a defined reset value.
            grid_next_q <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            gen_q   <= gen_d;
            if (state_q == COMPUTE && !edit) grid_next_q[row_q] <= row_new;
        end
    end

    assign grid_next     = grid_next_q;
    assign enable_update = (state_q == COMMIT);
    assign busy          = (state_q == COMPUTE) || (state_q == COMMIT);
    assign gen_count     = gen_q;

endmodule

// File: doc/gol_next_gen.md
Name: gol_next_gen

Overview:
Game-of-Life generation engine that sits directly upstream of the cell-state grid register. It reads the live 16x16 grid and computes the next generation one row per cycle into an internal buffer. It then pulses enable_update for one cycle so the grid loads grid_next. It also paces generations (free-run or single-step) and aborts a computation cleanly when the user edits a cell.

Parameters:
ROWS, 16, grid rows; fixed to 16 in this revision.
COLS, 16, grid columns; fixed to 16 in this revision.
GEN_PERIOD, 50_000_000, WAIT-state cycles between generations in run mode; must be >= 1.

Ports:
clk  in  1  system clock; all state updates on posedge
reset  in  1  asynchronous, active-low (asserted when 0); clears all state immediately
run  in  1  level; 1 = evolve continuously
step  in  1  single-cycle pulse; one generation, accepted only in IDLE with run=0
edit  in  1  tied to the grid's set_initial; aborts in-flight computation
grid  in  [15:0][15:0]  current cell states from the grid register
grid_next  out  [15:0][15:0]  computed next generation; valid while enable_update=1
enable_update  out  1  one-cycle load strobe to the grid register
busy  out  1  1 in COMPUTE or COMMIT
gen_count  out  16  generations committed since reset

Behaviour:
- Reset (reset=0, async): state=IDLE, row index=0, period counter=0; grid_next=0, enable_update=0, busy=0, gen_count=0.
- States: IDLE, WAIT, COMPUTE, COMMIT.
- IDLE:
  - run=1: go to WAIT and load the counter with GEN_PERIOD-1.
  - step=1 and run=0 and edit=0: go to COMPUTE with row=0.
  - Otherwise stay in IDLE.
- WAIT:
  - run=0: go to IDLE.
  - edit=1: reload the counter and stay in WAIT.
  - counter==0: go to COMPUTE with row=0.
  - Otherwise decrement the counter.
- COMPUTE: each cycle evaluates row r and writes it into grid_next[r].
  - r=15: go to COMMIT.
  - Otherwise r increments.
  - edit=1 in any COMPUTE cycle: abort. No commit; gen_count unchanged; go to WAIT (counter reloaded) if run=1, else IDLE.
- COMMIT:
  - enable_update=1 for exactly this cycle; gen_count increments, wrapping 0xFFFF->0.
  - Next state: WAIT (counter reloaded) if run=1, else IDLE.
- Cell rule:
  - n = live 8-neighbour count, 4-bit unsigned, range 0..8.
  - next = (n==3) | (alive & n==2).
  - Neighbours outside rows/cols 0..15 are dead; no wrap-around.
- Latency:
  - Trigger accepted at edge T (enter COMPUTE); rows 0..15 written at edges T+1..T+16.
  - enable_update is high from T+16 to T+17; the grid loads at T+17.
  - Step-to-load latency is 17 cycles.
  - Run-mode generation period is GEN_PERIOD+17 cycles.
- Run deasserted during COMPUTE: the computation finishes, commits, then goes to IDLE.
- step while run=1, or outside IDLE: ignored, not queued.
- edit and step both high in IDLE: step ignored.
- grid must be stable during COMPUTE; edit is the only legal source of change and always aborts.
- grid_next rows outside the current computation hold stale values; consumers may use grid_next only under enable_update.
- Reset mid-operation: immediate return to the reset values; no enable_update pulse.

Decomposition:
- Package gol_pkg holds:
  - ROWS and COLS constants.
  - typedef logic [ROWS-1:0][COLS-1:0] grid_t.
  - typedef logic [COLS-1:0] row_t.
  - State enum state_t {IDLE, WAIT, COMPUTE, COMMIT}.
- Sub-module gol_row_eval (combinational):
  - Inputs: row_t above, cur, below.
  - Output: row_t next, with dead column edges.
  - Parent muxes rows r-1, r, r+1 and substitutes 0 beyond rows 0 and 15.

Test Plan:
- Blinker, run=0: cells (8,8),(9,8),(10,8), step pulse -> enable_update after 17 cycles; grid_next has only (9,7),(9,8),(9,9); gen_count=1.
- Still-life block: (4,4),(4,5),(5,4),(5,5), two steps -> grid_next identical both times; gen_count=2.
- Corner/no wrap: (0,0),(0,1),(1,0) -> next is (0,0),(0,1),(1,0),(1,1). Separately, single cell (15,15) dies; row 0 and col 0 stay 0.
- Run pacing, GEN_PERIOD=4: run=1 with blinker -> enable_update pulses 21 cycles apart; orientation alternates; gen_count counts 1,2,3.
- Edit abort: step, then edit=1 at the 6th COMPUTE cycle -> no enable_update, gen_count unchanged, state IDLE, busy=0.
- Async reset: reset=0 mid-COMPUTE between edges -> outputs zero immediately; no strobe after release until a new step.
